// File: rtl/orao_tape_rec.sv
// Cassette recorder: samples the 1-bit tape output at SAMPLE_HZ and streams an
// 8-bit mono WAV (44-byte header, then samples) through a show-ahead FIFO.
module orao_tape_rec #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned SAMPLE_HZ  = 44100,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        tape_bit,
  input  logic        rec_en,
  input  logic        rd,
  output logic [7:0]  dout,
  output logic        empty,
  output logic        rec_active,
  output logic        overflow,
  output logic [31:0] byte_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] SR = 32'(SAMPLE_HZ);
  localparam logic [31:0] SR_LE = {SR[7:0], SR[15:8], SR[23:16], SR[31:24]};
  localparam logic [32:0] SAMPLE_W = 33'(SAMPLE_HZ);
  localparam logic [32:0] CLK_W = 33'(CLK_HZ);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  // Header listed first byte first; multi-byte fields are already little-endian.
  localparam logic [44*8-1:0] HDR_BE = {
    "RIFF", 32'hFFFF_FFFF, "WAVE", "fmt ", 32'h1000_0000,
    16'h0100, 16'h0100, SR_LE, SR_LE, 16'h0100, 16'h0800,
    "data", 32'hFFFF_FFFF
  };

  typedef enum logic [1:0] {IDLE, HEADER, STREAM} state_t;

  state_t          state_q, state_d;
  logic            rec_en_q;
  logic [5:0]      idx_q;
  logic [31:0]     acc_q, acc_d;
  logic [32:0]     acc_sum;
  logic            tick;
  logic            push_req, push, pop, drop, full, rise;
  logic [7:0]      push_data;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q;
  logic [31:0]     byte_count_q;
  logic [7:0]      hdr_rom [64];

  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_hdr
      if (gi < 44) begin : g_byte
        assign hdr_rom[gi] = HDR_BE[(43-gi)*8 +: 8];
      end else begin : g_pad
        assign hdr_rom[gi] = 8'h00;
      end
    end
  endgenerate

  assign rise  = rec_en & ~rec_en_q;
  assign full  = (count_q == FULL_CNT);
  assign push  = push_req & ~full;
  assign drop  = tick & full;
  assign pop   = rd & (count_q != '0);

  always_ff @(posedge clk_sys) begin : fsm_reg
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      IDLE:    if (rise) state_d = HEADER;
      HEADER: begin
        if (!rec_en)                      state_d = IDLE;
        else if (push && idx_q == 6'd43)  state_d = STREAM;
      end
      STREAM:  if (!rec_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Accumulator is only advanced in STREAM, so it sits at 0 everywhere else.
  always_comb begin : fsm_out
    tick      = 1'b0;
    acc_d     = '0;
    push_req  = 1'b0;
    push_data = 8'h00;
    acc_sum   = {1'b0, acc_q} + SAMPLE_W;
    case (state_q)
      HEADER: begin
        push_req  = rec_en;
        push_data = hdr_rom[idx_q];
      end
      STREAM: begin
        if (acc_sum >= CLK_W) begin
          tick  = 1'b1;
          acc_d = 32'(acc_sum - CLK_W);
        end else begin
          acc_d = acc_sum[31:0];
        end
        push_req  = tick;
        push_data = tape_bit ? 8'hC0 : 8'h40;
      end
      default: ;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      rec_en_q     <= 1'b0;
      acc_q        <= '0;
      idx_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      byte_count_q <= '0;
    end else begin
      rec_en_q <= rec_en;
      acc_q    <= acc_d;
      count_q  <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (state_q == IDLE && rise) begin
        idx_q        <= '0;
        overflow_q   <= 1'b0;
        byte_count_q <= '0;
      end else begin
        if (push)                     byte_count_q <= byte_count_q + 32'd1;
        if (drop)                     overflow_q   <= 1'b1;
        if (push && state_q == HEADER) idx_q       <= idx_q + 6'd1;
      end
    end
  end

  assign empty      = (count_q == '0);
  assign dout       = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign rec_active = (state_q == HEADER) || (state_q == STREAM);
  assign overflow   = overflow_q;
  assign byte_count = byte_count_q;

endmodule
